// File: rtl/elevator_controller.sv
`timescale 1ns/1ps
// elevator_controller
// ---------------------------------------------------------------------------
// Parametrised N-floor elevator core. Latches hall calls, serves them in
// SCAN order (the car keeps its direction while requests remain ahead of
// it), times floor-to-floor travel and door dwell, and handles the SOS and
// overweight conditions inside a single FSM. Every output is a register.
//
// Ports:
//   clk                   divided tick clock
//   reset_n               asynchronous active-low reset
//   call_req[FLOORS]      single-cycle call pulses, bit i = floor i
//   sos                   emergency level, synchronous to clk
//   overweight            load-sensor level, synchronous to clk
//   call_pending[FLOORS]  latched, unserved calls
//   floor_onehot[FLOORS]  current floor, one-hot
//   floor_num[FLOOR_W]    current floor, binary
//   door_open             door open
//   moving                car travelling
//   dir_up                current/last scan direction, 1 = up
//   sos_mode              SOS state active
//   weight_limit_exceeded overweight is blocking departure
// ---------------------------------------------------------------------------
module elevator_controller #(
  parameter int FLOORS       = 8,
  parameter int TRAVEL_TICKS = 3,
  parameter int DOOR_TICKS   = 4,
  localparam int FLOOR_W     = $clog2(FLOORS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [FLOORS-1:0]  call_req,
  input  logic               sos,
  input  logic               overweight,
  output logic [FLOORS-1:0]  call_pending,
  output logic [FLOORS-1:0]  floor_onehot,
  output logic [FLOOR_W-1:0] floor_num,
  output logic               door_open,
  output logic               moving,
  output logic               dir_up,
  output logic               sos_mode,
  output logic               weight_limit_exceeded
);

  // One extra bit so a tick count of 1 still gets a legal, non-zero width.
  localparam int TW = $clog2(TRAVEL_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0] TRAVEL_RELOAD = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_RELOAD   = DW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    DOOR_OPEN,
    SOS
  } state_t;

  state_t             state, state_n;
  state_t             saved_state, saved_n;
  logic [TW-1:0]      travel_cnt, travel_n;
  logic [DW-1:0]      door_cnt, door_cnt_n;
  logic [FLOOR_W-1:0] floor_n;
  logic [FLOORS-1:0]  floor_oh_n;
  logic [FLOORS-1:0]  pending_n;
  logic               door_n, moving_n, dir_n, sos_mode_n, wle_n;

  logic [FLOORS-1:0]  pend_or;
  logic               here_call;
  logic               req_above, req_below;
  logic [FLOOR_W-1:0] step_floor;
  logic [FLOORS-1:0]  step_oh;
  logic               at_limit;

  // Request scan relative to the current floor, plus the floor the car
  // would reach on its next one-floor step in the current direction.
  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (call_pending[i] && (FLOOR_W'(i) > floor_num)) req_above = 1'b1;
      if (call_pending[i] && (FLOOR_W'(i) < floor_num)) req_below = 1'b1;
    end
    step_floor = dir_up ? floor_num + FLOOR_W'(1) : floor_num - FLOOR_W'(1);
    at_limit   = dir_up ? (floor_num == FLOOR_W'(FLOORS - 1)) : (floor_num == '0);
    step_oh    = '0;
    for (int i = 0; i < FLOORS; i++) begin
      step_oh[i] = (step_floor == FLOOR_W'(i));
    end
    pend_or   = call_pending | call_req;
    here_call = |(call_req & floor_onehot);
  end

  // Next-state and next-output logic. SOS is checked first so it overrides
  // every other transition; while in SOS the counters, floor and pending
  // calls are simply left untouched, which is what preserves them.
  always_comb begin
    state_n    = state;
    saved_n    = saved_state;
    travel_n   = travel_cnt;
    door_cnt_n = door_cnt;
    floor_n    = floor_num;
    pending_n  = call_pending;
    door_n     = door_open;
    moving_n   = moving;
    dir_n      = dir_up;
    sos_mode_n = sos_mode;
    wle_n      = 1'b0;

    if (sos) begin
      state_n    = SOS;
      sos_mode_n = 1'b1;
      moving_n   = 1'b0;
      if (state != SOS) saved_n = state;
    end else begin
      case (state)
        IDLE: begin
          moving_n  = 1'b0;
          door_n    = 1'b0;
          pending_n = pend_or & ~floor_onehot;
          if (here_call) begin
            state_n    = DOOR_OPEN;
            door_n     = 1'b1;
            door_cnt_n = DOOR_RELOAD;
          end else if (dir_up ? req_above : req_below) begin
            state_n  = MOVING;
            moving_n = 1'b1;
            travel_n = TRAVEL_RELOAD;
          end else if (dir_up ? req_below : req_above) begin
            state_n  = MOVING;
            moving_n = 1'b1;
            dir_n    = ~dir_up;
            travel_n = TRAVEL_RELOAD;
          end
        end

        MOVING: begin
          moving_n  = 1'b1;
          pending_n = pend_or;
          if (travel_cnt != '0) begin
            travel_n = travel_cnt - TW'(1);
          end else if (at_limit) begin
            // Direction is only ever chosen toward a request, so this is a
            // safety stop rather than a normal path.
            state_n  = IDLE;
            moving_n = 1'b0;
          end else begin
            floor_n = step_floor;
            if (|(pend_or & step_oh)) begin
              pending_n  = pend_or & ~step_oh;
              state_n    = DOOR_OPEN;
              door_n     = 1'b1;
              moving_n   = 1'b0;
              door_cnt_n = DOOR_RELOAD;
            end else begin
              travel_n = TRAVEL_RELOAD;
            end
          end
        end

        DOOR_OPEN: begin
          door_n    = 1'b1;
          wle_n     = overweight;
          pending_n = pend_or & ~floor_onehot;
          if (here_call) begin
            door_cnt_n = DOOR_RELOAD;
          end else if (door_cnt != '0) begin
            door_cnt_n = door_cnt - DW'(1);
          end else if (!overweight) begin
            state_n = IDLE;
            door_n  = 1'b0;
          end
        end

        SOS: begin
          sos_mode_n = 1'b0;
          case (saved_state)
            MOVING: begin
              state_n  = MOVING;
              moving_n = 1'b1;
            end
            DOOR_OPEN: begin
              state_n    = DOOR_OPEN;
              door_cnt_n = DOOR_RELOAD;
            end
            default: state_n = IDLE;
          endcase
        end

        default: state_n = IDLE;
      endcase
    end

    floor_oh_n = '0;
    for (int i = 0; i < FLOORS; i++) begin
      floor_oh_n[i] = (floor_n == FLOOR_W'(i));
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      saved_state           <= IDLE;
      travel_cnt            <= '0;
      door_cnt              <= '0;
      floor_num             <= '0;
      floor_onehot          <= FLOORS'(1);
      call_pending          <= '0;
      door_open             <= 1'b0;
      moving                <= 1'b0;
      dir_up                <= 1'b1;
      sos_mode              <= 1'b0;
      weight_limit_exceeded <= 1'b0;
    end else begin
      state                 <= state_n;
      saved_state           <= saved_n;
      travel_cnt            <= travel_n;
      door_cnt              <= door_cnt_n;
      floor_num             <= floor_n;
      floor_onehot          <= floor_oh_n;
      call_pending          <= pending_n;
      door_open             <= door_n;
      moving                <= moving_n;
      dir_up                <= dir_n;
      sos_mode              <= sos_mode_n;
      weight_limit_exceeded <= wle_n;
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
`timescale 1ns/1ps
// tb_elevator_controller
// ---------------------------------------------------------------------------
// Directed bench for a 4-floor, 3-tick travel, 2-tick door configuration.
// Expected output snapshots are queued when stimulus is applied and popped
// and compared after the clock edge that consumes that stimulus.
// ---------------------------------------------------------------------------
module tb_elevator_controller;

  localparam int FLOORS = 4;

  logic              clk;
  logic              reset_n;
  logic [FLOORS-1:0] call_req;
  logic              sos;
  logic              overweight;
  logic [FLOORS-1:0] call_pending;
  logic [FLOORS-1:0] floor_onehot;
  logic [1:0]        floor_num;
  logic              door_open;
  logic              moving;
  logic              dir_up;
  logic              sos_mode;
  logic              weight_limit_exceeded;

  typedef struct {
    string       tag;
    logic [14:0] value;
  } exp_t;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  elevator_controller #(
    .FLOORS(FLOORS),
    .TRAVEL_TICKS(3),
    .DOOR_TICKS(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .call_req(call_req),
    .sos(sos),
    .overweight(overweight),
    .call_pending(call_pending),
    .floor_onehot(floor_onehot),
    .floor_num(floor_num),
    .door_open(door_open),
    .moving(moving),
    .dir_up(dir_up),
    .sos_mode(sos_mode),
    .weight_limit_exceeded(weight_limit_exceeded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] c, input logic s, input logic ow);
    call_req   = c;
    sos        = s;
    overweight = ow;
  endtask

  task automatic push_expected(input string tag, input logic [3:0] pend, input int f,
                               input logic d, input logic m, input logic up,
                               input logic sm, input logic wle);
    exp_t e;
    logic [3:0] oh;
    oh = 4'b0001 << f;
    e.tag   = tag;
    e.value = {pend, oh, 2'(f), d, m, up, sm, wle};
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t        e;
    logic [14:0] obs;
    tests_run++;
    assert (sb.size() > 0) else begin
      tests_failed++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1 entries");
    end
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {call_pending, floor_onehot, floor_num, door_open, moving, dir_up,
             sos_mode, weight_limit_exceeded};
      assert (obs === e.value) else begin
        tests_failed++;
        $error("[TB] FAIL %s observed={pend,oh,floor,door,mov,up,sos,wle}=%b expected=%b",
               e.tag, obs, e.value);
      end
    end
  endtask

  // One clocked step: drive inputs, queue expectation, clock, compare.
  task automatic step(input string tag, input logic [3:0] c, input logic s, input logic ow,
                      input logic [3:0] pend, input int f, input logic d, input logic m,
                      input logic up, input logic sm, input logic wle);
    apply_stimulus(c, s, ow);
    push_expected(tag, pend, f, d, m, up, sm, wle);
    tick();
    check_output();
  endtask

  task automatic run(input int n);
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    push_expected("reset_state", 4'b0000, 0, 0, 0, 1, 0, 0);
    check_output();
    reset_n = 1'b1;

    // Single call to floor 2 from ground.
    step("call2_latch", 4'b0100, 0, 0, 4'b0100, 0, 0, 0, 1, 0, 0);
    step("depart",      4'b0000, 0, 0, 4'b0100, 0, 0, 1, 1, 0, 0);
    run(2);
    step("floor1",      4'b0000, 0, 0, 4'b0100, 1, 0, 1, 1, 0, 0);
    run(2);
    step("arrive2",     4'b0000, 0, 0, 4'b0000, 2, 1, 0, 1, 0, 0);
    step("door_hold",   4'b0000, 0, 0, 4'b0000, 2, 1, 0, 1, 0, 0);
    step("door_close",  4'b0000, 0, 0, 4'b0000, 2, 0, 0, 1, 0, 0);

    // Call at the current floor opens the door without latching.
    step("same_floor",  4'b0100, 0, 0, 4'b0000, 2, 1, 0, 1, 0, 0);
    run(1);
    step("same_floor_close", 4'b0000, 0, 0, 4'b0000, 2, 0, 0, 1, 0, 0);

    // Downward trip interrupted by an asynchronous reset.
    step("call0_latch", 4'b0001, 0, 0, 4'b0001, 2, 0, 0, 1, 0, 0);
    step("reverse",     4'b0000, 0, 0, 4'b0001, 2, 0, 1, 0, 0, 0);
    step("mid_travel",  4'b0000, 0, 0, 4'b0001, 2, 0, 1, 0, 0, 0);
    reset_n = 1'b0;
    #2;
    push_expected("async_reset", 4'b0000, 0, 0, 0, 1, 0, 0);
    check_output();
    tick();
    reset_n = 1'b1;

    // SCAN ordering: up to 3 with stops at 1, then back down to 0.
    step("scan_call3",   4'b1000, 0, 0, 4'b1000, 0, 0, 0, 1, 0, 0);
    step("scan_depart",  4'b0000, 0, 0, 4'b1000, 0, 0, 1, 1, 0, 0);
    step("scan_call1",   4'b0010, 0, 0, 4'b1010, 0, 0, 1, 1, 0, 0);
    step("scan_call0",   4'b0001, 0, 0, 4'b1011, 0, 0, 1, 1, 0, 0);
    step("scan_stop1",   4'b0000, 0, 0, 4'b1001, 1, 1, 0, 1, 0, 0);
    run(1);
    step("scan_idle1",   4'b0000, 0, 0, 4'b1001, 1, 0, 0, 1, 0, 0);
    step("scan_keep_up", 4'b0000, 0, 0, 4'b1001, 1, 0, 1, 1, 0, 0);
    run(5);
    step("scan_stop3",   4'b0000, 0, 0, 4'b0001, 3, 1, 0, 1, 0, 0);
    run(2);
    step("scan_reverse", 4'b0000, 0, 0, 4'b0001, 3, 0, 1, 0, 0, 0);
    run(8);
    step("scan_stop0",   4'b0000, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 0);
    run(2);

    // SOS one cycle into a travel segment, with a call ignored during SOS.
    step("sos_call2",       4'b0100, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0);
    step("sos_depart",      4'b0000, 0, 0, 4'b0100, 0, 0, 1, 1, 0, 0);
    run(1);
    step("sos_enter",       4'b0000, 1, 0, 4'b0100, 0, 0, 0, 1, 1, 0);
    step("sos_ignore_call", 4'b0010, 1, 0, 4'b0100, 0, 0, 0, 1, 1, 0);
    step("sos_resume",      4'b0000, 0, 0, 4'b0100, 0, 0, 1, 1, 0, 0);
    step("sos_remaining",   4'b0000, 0, 0, 4'b0100, 0, 0, 1, 1, 0, 0);
    step("sos_arrive1",     4'b0000, 0, 0, 4'b0100, 1, 0, 1, 1, 0, 0);
    run(2);

    // Overweight holds the door past its dwell time.
    step("ow_arrive2",  4'b0000, 0, 0, 4'b0000, 2, 1, 0, 1, 0, 0);
    step("ow_set",      4'b0000, 0, 1, 4'b0000, 2, 1, 0, 1, 0, 1);
    step("ow_hold",     4'b0000, 0, 1, 4'b0000, 2, 1, 0, 1, 0, 1);
    step("ow_hold2",    4'b0000, 0, 1, 4'b0000, 2, 1, 0, 1, 0, 1);
    step("ow_release",  4'b0000, 0, 0, 4'b0000, 2, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Parametrised N-floor elevator core. Successor to the fixed 3-floor movement/emergency pair.
- Latches hall calls, schedules them SCAN-style (keeps direction while requests remain ahead), times floor travel and door dwell, and owns SOS and overweight handling in one FSM.
- Sits behind the frequency divider and button handler. Its outputs drive LEDs and the display decoders directly.

Parameters:
- FLOORS, 8, number of floors (>=2); floor 0 is ground.
- TRAVEL_TICKS, 3, clk cycles to travel one floor (>=1).
- DOOR_TICKS, 4, clk cycles the door stays open (>=1).
- FLOOR_W, $clog2(FLOORS), width of floor index (derived, not overridden).

Ports:
- clk  input  1  divided tick clock from frequency block
- reset_n  input  1  asynchronous active-low reset
- call_req  input  FLOORS  single-cycle call pulses from button handler; bit i = floor i
- sos  input  1  emergency level, synchronous to clk
- overweight  input  1  load-sensor level, synchronous to clk
- call_pending  output  FLOORS  latched, unserved calls (call LEDs)
- floor_onehot  output  FLOORS  current floor, one-hot
- floor_num  output  FLOOR_W  current floor, binary (display)
- door_open  output  1  door open
- moving  output  1  car travelling
- dir_up  output  1  current/last scan direction, 1 = up
- sos_mode  output  1  SOS state active
- weight_limit_exceeded  output  1  overweight blocking departure

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, floor_num 0, floor_onehot bit0 = 1, call_pending 0, door_open 0, moving 0, dir_up 1, sos_mode 0, weight_limit_exceeded 0, counters 0.
- States: IDLE, MOVING, DOOR_OPEN, SOS. All outputs are registered.
- Call latching: pending_next = (pending | call_req) & ~served.
  - served = current-floor bit on arrival, or call_req at the current floor while in IDLE/DOOR_OPEN.
  - A call at the current floor never shows in call_pending.
  - call_req is ignored in SOS.
- IDLE:
  - call_req at current floor -> DOOR_OPEN next cycle, door counter = DOOR_TICKS-1.
  - else if any pending in dir_up direction -> keep dir; else if any pending opposite -> flip dir_up.
  - Then go to MOVING with travel counter = TRAVEL_TICKS-1.
  - No pending -> stay in IDLE.
- MOVING: moving = 1. Counter decrements each cycle. At counter 0, floor moves ±1 per dir_up, then:
  - if (pending | call_req)[new floor] -> clear that bit, go to DOOR_OPEN, door counter = DOOR_TICKS-1;
  - else reload travel counter and continue.
  - Floor never passes 0 or FLOORS-1; direction is chosen only toward existing requests.
- DOOR_OPEN: door_open = 1. Counter decrements each cycle.
  - call_req at current floor reloads the counter to DOOR_TICKS-1.
  - At counter 0 with overweight = 0 -> IDLE. Re-scheduling happens from IDLE, so there is one extra cycle of latency.
  - At counter 0 with overweight = 1 -> hold in DOOR_OPEN.
- weight_limit_exceeded: registered. Set when overweight = 1 while in DOOR_OPEN; cleared the cycle after overweight = 0. Never set outside DOOR_OPEN.
- SOS:
  - sos = 1 in any state -> SOS next cycle; sos_mode = 1, moving = 0.
  - Saved: prior state, travel counter, floor, pending. door_open keeps its prior value.
  - On sos = 0: resume the saved state. MOVING continues with the remaining ticks; DOOR_OPEN reloads its counter to DOOR_TICKS-1; IDLE resumes as IDLE.
  - SOS has priority over every other transition in the same cycle.
- Reset mid-operation: all state returns to reset values immediately; pending calls are lost.

Test Plan:
- Reset: assert reset_n = 0 mid-travel -> all outputs equal reset values asynchronously; floor_num = 0, call_pending = 0.
- FLOORS=4, TRAVEL_TICKS=3, DOOR_TICKS=2, from floor 0: pulse call_req = 4'b0100 -> call_pending = 0100; moving rises next cycle; floor_num = 1 three cycles later, 2 three cycles after that; then door_open = 1 and call_pending = 0; door_open held 2 cycles; then IDLE.
- SCAN order: car at 0 heading up to 3; pulse call 1 before arrival at 1, then call 0 -> stops at 1, then 3, then reverses (dir_up = 0) to 0.
- Same-floor call: IDLE at floor 2, pulse call_req bit2 -> door_open = 1 next cycle, call_pending stays 0.
- SOS: assert sos one cycle into a 3-tick segment -> sos_mode = 1, moving = 0, floor frozen; deassert -> moving resumes and arrives after the remaining 2 ticks.
- Overweight: overweight = 1 during DOOR_OPEN -> weight_limit_exceeded = 1, door stays open past DOOR_TICKS; drop overweight -> flag clears next cycle, door closes next cycle.
